ras_ckpt: RTL and testbench

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/bpred_pkg.sv | 23 ++
 rtl/ras_storage.sv | 34 +++
 rtl/ras_ckpt.sv | 137 +++++++++++++
 tb/tb_ras_ckpt.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// ============================================================================
// Module : bpred_pkg
// Desc   : Shared branch-predictor defaults and the RAS checkpoint record.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bpred_pkg;

    localparam int RAS_DEPTH_DEF = 16;
    localparam int BP_AW         = 32;
    localparam int RAS_IW_DEF    = $clog2(RAS_DEPTH_DEF);

    // Checkpoint travelling with a branch so execute can repair the RAS.
    typedef struct packed {
        logic [RAS_IW_DEF-1:0] index;
        logic [RAS_IW_DEF:0]   count;
        logic [BP_AW-1:0]      top;
    } ras_ckpt_t;

endpackage

`default_nettype wire

// File: rtl/ras_storage.sv
// ============================================================================
// Module : ras_storage
// Desc   : DEPTH x AW return-address register file, 1 write / 1 async read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ras_storage #(
    parameter int DEPTH = 16,
    parameter int AW    = 32,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem_q [DEPTH];

    // Contents are deliberately left unreset; top_valid masks stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/ras_ckpt.sv
// ============================================================================
// Module : ras_ckpt
// Desc   : Checkpointed return-address stack with misprediction recovery.
//          Define RAS_CKPT_TOP_EN to also repair the top entry on recovery.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ras_ckpt
    import bpred_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int AW    = BP_AW,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_stall,
    input  logic          f_push,
    input  logic [AW-1:0] f_push_addr,
    input  logic          f_pop,
    output logic [AW-1:0] top_addr,
    output logic          top_valid,
    output logic [IW-1:0] ckpt_index,
    output logic [IW:0]   ckpt_count,
    output logic [AW-1:0] ckpt_top,
    input  logic          e_recover,
    input  logic [IW-1:0] e_recover_index,
    input  logic [IW:0]   e_recover_count,
    input  logic [AW-1:0] e_recover_top,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [IW:0] CNT_FULL = (IW+1)'(DEPTH);

    logic [IW-1:0] tos_q, tos_d;
    logic [IW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          do_push, do_pop;
    logic          we, we_gated;
    logic [IW-1:0] waddr;
    logic [AW-1:0] wdata;
    logic [AW-1:0] rdata;

    assign do_push = f_push & ~f_stall;
    assign do_pop  = f_pop  & ~f_stall;

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        we          = 1'b0;
        waddr       = tos_q;
        wdata       = f_push_addr;
        if (e_recover) begin
            tos_d   = e_recover_index;
            count_d = e_recover_count;
`ifdef RAS_CKPT_TOP_EN
            we      = 1'b1;
            waddr   = e_recover_index;
            wdata   = e_recover_top;
`endif
        end else if (do_push && (!do_pop || count_q == '0)) begin
            // Push+pop on an empty stack degenerates to a plain push.
            tos_d = tos_q + IW'(1);
            waddr = tos_q + IW'(1);
            we    = 1'b1;
            if (count_q == CNT_FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + (IW+1)'(1);
            end
        end else if (do_push && do_pop) begin
            we    = 1'b1;
            waddr = tos_q;
        end else if (do_pop) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                tos_d   = tos_q - IW'(1);
                count_d = count_q - (IW+1)'(1);
            end
        end
    end

    // No storage write may land on an edge that occurs while reset is held.
    assign we_gated = we & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    ras_storage #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_storage (
        .clk   (clk),
        .we    (we_gated),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (tos_q),
        .rdata (rdata)
    );

    assign top_valid  = (count_q != '0);
    assign top_addr   = top_valid ? rdata : '0;
    assign ckpt_index = tos_q;
    assign ckpt_count = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef RAS_CKPT_TOP_EN
    assign ckpt_top = top_addr;
`else
    logic unused_recover_top;
    assign unused_recover_top = ^e_recover_top;
    assign ckpt_top           = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ras_ckpt.sv
// ============================================================================
// Module : tb_ras_ckpt
// Desc   : Directed self-checking bench for ras_ckpt at DEPTH=4, AW=32.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ras_ckpt;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int IW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_stall;
    logic          f_push;
    logic [AW-1:0] f_push_addr;
    logic          f_pop;
    logic [AW-1:0] top_addr;
    logic          top_valid;
    logic [IW-1:0] ckpt_index;
    logic [IW:0]   ckpt_count;
    logic [AW-1:0] ckpt_top;
    logic          e_recover;
    logic [IW-1:0] e_recover_index;
    logic [IW:0]   e_recover_count;
    logic [AW-1:0] e_recover_top;
    logic          overflow;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ras_ckpt #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .f_stall         (f_stall),
        .f_push          (f_push),
        .f_push_addr     (f_push_addr),
        .f_pop           (f_pop),
        .top_addr        (top_addr),
        .top_valid       (top_valid),
        .ckpt_index      (ckpt_index),
        .ckpt_count      (ckpt_count),
        .ckpt_top        (ckpt_top),
        .e_recover       (e_recover),
        .e_recover_index (e_recover_index),
        .e_recover_count (e_recover_count),
        .e_recover_top   (e_recover_top),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    task automatic clear_inputs();
        f_stall         = 1'b0;
        f_push          = 1'b0;
        f_pop           = 1'b0;
        f_push_addr     = '0;
        e_recover       = 1'b0;
        e_recover_index = '0;
        e_recover_count = '0;
        e_recover_top   = '0;
    endtask

    // One clock with the given fetch controls; returns at posedge+1.
    task automatic cyc(input logic push, input logic pop, input logic stall,
                       input logic [AW-1:0] addr);
        f_push      = push;
        f_pop       = pop;
        f_stall     = stall;
        f_push_addr = addr;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (top_valid !== 1'b0 || top_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_top got valid=%0b addr=%0h exp valid=0 addr=0", top_valid, top_addr);
        end
        checks++;
        if (ckpt_index !== 2'd0 || ckpt_count !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got idx=%0d cnt=%0d ovf=%0b unf=%0b exp 0 0 0 0",
                     ckpt_index, ckpt_count, overflow, underflow);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h100);
        cyc(1'b1, 1'b0, 1'b0, 32'h200);
        checks++;
        if (top_addr !== 32'h200 || ckpt_count !== 3'd2 || ckpt_index !== 2'd2) begin
            failures++;
            $display("FAIL push2 got top=%0h cnt=%0d idx=%0d exp top=200 cnt=2 idx=2",
                     top_addr, ckpt_count, ckpt_index);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (top_addr !== 32'h100 || ckpt_count !== 3'd1 || top_valid !== 1'b1) begin
            failures++;
            $display("FAIL pop1 got top=%0h cnt=%0d valid=%0b exp top=100 cnt=1 valid=1",
                     top_addr, ckpt_count, top_valid);
        end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] pushes [5];
        logic [AW-1:0] pops   [4];
        pushes = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
        pops   = '{32'hE0, 32'hD0, 32'hC0, 32'hB0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, pushes[i]);
            checks++;
            if (overflow !== (i == 4)) begin
                failures++;
                $display("FAIL ovf_push%0d got=%0b exp=%0b", i, overflow, (i == 4));
            end
        end
        checks++;
        if (ckpt_count !== 3'd4 || top_addr !== 32'hE0) begin
            failures++;
            $display("FAIL ovf_full got cnt=%0d top=%0h exp cnt=4 top=e0", ckpt_count, top_addr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (top_addr !== pops[i]) begin
                failures++;
                $display("FAIL ovf_pop%0d got=%0h exp=%0h", i, top_addr, pops[i]);
            end
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (overflow !== 1'b0) begin
                failures++;
                $display("FAIL ovf_clear%0d got=%0b exp=0", i, overflow);
            end
        end
        checks++;
        if (top_valid !== 1'b0 || ckpt_count !== 3'd0) begin
            failures++;
            $display("FAIL ovf_empty got valid=%0b cnt=%0d exp valid=0 cnt=0", top_valid, ckpt_count);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (underflow !== 1'b1 || ckpt_index !== 2'd0 || ckpt_count !== 3'd0 || top_addr !== 32'h0) begin
            failures++;
            $display("FAIL unf_pulse got unf=%0b idx=%0d cnt=%0d top=%0h exp 1 0 0 0",
                     underflow, ckpt_index, ckpt_count, top_addr);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL unf_once got=%0b exp=0", underflow);
        end
        // Push+pop at empty acts as a push, with no underflow.
        cyc(1'b1, 1'b1, 1'b0, 32'h44);
        checks++;
        if (underflow !== 1'b0 || top_addr !== 32'h44 || ckpt_count !== 3'd1 || ckpt_index !== 2'd1) begin
            failures++;
            $display("FAIL pushpop_empty got unf=%0b top=%0h cnt=%0d idx=%0d exp 0 44 1 1",
                     underflow, top_addr, ckpt_count, ckpt_index);
        end
    endtask

    task automatic test_recover();
        logic [AW-1:0] exp_top;
        logic [AW-1:0] exp_ckpt_top;
`ifdef RAS_CKPT_TOP_EN
        exp_top      = 32'h200;
        exp_ckpt_top = 32'h200;
`else
        exp_top      = 32'h900;
        exp_ckpt_top = 32'h0;
`endif
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h100);
        cyc(1'b1, 1'b0, 1'b0, 32'h200);
        checks++;
        if (ckpt_index !== 2'd2 || ckpt_count !== 3'd2 || ckpt_top !== exp_ckpt_top) begin
            failures++;
            $display("FAIL ckpt_capture got idx=%0d cnt=%0d top=%0h exp idx=2 cnt=2 top=%0h",
                     ckpt_index, ckpt_count, ckpt_top, exp_ckpt_top);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h900);
        e_recover       = 1'b1;
        e_recover_index = 2'd2;
        e_recover_count = 3'd2;
        e_recover_top   = 32'h200;
        @(posedge clk);
        #1;
        clear_inputs();
        checks++;
        if (top_addr !== exp_top || ckpt_index !== 2'd2 || ckpt_count !== 3'd2) begin
            failures++;
            $display("FAIL recover got top=%0h idx=%0d cnt=%0d exp top=%0h idx=2 cnt=2",
                     top_addr, ckpt_index, ckpt_count, exp_top);
        end
    endtask

    task automatic test_same_cycle();
        logic [AW-1:0] exp_top;
`ifdef RAS_CKPT_TOP_EN
        exp_top = 32'h100;
`else
        exp_top = 32'h300;
`endif
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h100);
        cyc(1'b1, 1'b1, 1'b0, 32'h300);
        checks++;
        if (top_addr !== 32'h300 || ckpt_count !== 3'd1 || ckpt_index !== 2'd1) begin
            failures++;
            $display("FAIL pushpop got top=%0h cnt=%0d idx=%0d exp top=300 cnt=1 idx=1",
                     top_addr, ckpt_count, ckpt_index);
        end
        // Recover and push together, with stall high too: recover must win.
        e_recover       = 1'b1;
        e_recover_index = 2'd1;
        e_recover_count = 3'd1;
        e_recover_top   = 32'h100;
        f_push          = 1'b1;
        f_stall         = 1'b1;
        f_push_addr     = 32'h777;
        @(posedge clk);
        #1;
        clear_inputs();
        checks++;
        if (top_addr !== exp_top || ckpt_count !== 3'd1 || ckpt_index !== 2'd1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL recover_wins got top=%0h cnt=%0d idx=%0d ovf=%0b exp top=%0h cnt=1 idx=1 ovf=0",
                     top_addr, ckpt_count, ckpt_index, overflow, exp_top);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (top_valid !== 1'b0 || ckpt_index !== 2'd0) begin
            failures++;
            $display("FAIL recover_nopush got valid=%0b idx=%0d exp valid=0 idx=0", top_valid, ckpt_index);
        end
    endtask

    task automatic test_stall_reset();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h100);
        cyc(1'b1, 1'b0, 1'b0, 32'h200);
        for (int i = 0; i < 3; i++) begin
            cyc(i[0] == 1'b0, i[0] == 1'b1, 1'b1, 32'h5000 + i);
            checks++;
            if (top_addr !== 32'h200 || ckpt_count !== 3'd2 || ckpt_index !== 2'd2 ||
                overflow !== 1'b0 || underflow !== 1'b0) begin
                failures++;
                $display("FAIL stall%0d got top=%0h cnt=%0d idx=%0d ovf=%0b unf=%0b exp 200 2 2 0 0",
                         i, top_addr, ckpt_count, ckpt_index, overflow, underflow);
            end
        end
        // Assert reset between edges and look before the next edge arrives.
        f_push      = 1'b1;
        f_push_addr = 32'h999;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ckpt_count !== 3'd0 || top_valid !== 1'b0 || top_addr !== 32'h0 || ckpt_index !== 2'd0) begin
            failures++;
            $display("FAIL async_reset got cnt=%0d valid=%0b top=%0h idx=%0d exp 0 0 0 0",
                     ckpt_count, top_valid, top_addr, ckpt_index);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        checks++;
        if (ckpt_count !== 3'd0 || ckpt_index !== 2'd0) begin
            failures++;
            $display("FAIL reset_hold got cnt=%0d idx=%0d exp 0 0", ckpt_count, ckpt_index);
        end
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_recover();
        test_same_cycle();
        test_stall_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
